// File: rtl/word_slicer_if.sv
// Valid/ready bundle for word_slicer: wide words in, narrow slices out.
interface word_slicer_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/word_slicer.sv
// Buffers wide sample words in a small FIFO and emits narrow slices, either one
// offset window per word or every slice of the word LSB first.
module word_slicer #(
    parameter int  IN_W  = 32,
    parameter int  OUT_W = 8,
    parameter int  STEP  = 2,
    parameter int  DEPTH = 4,
    localparam int SH_W  = $clog2(IN_W / STEP),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    word_slicer_if.slave     bus,
    input  logic             mode,
    input  logic [SH_W-1:0]  sh_amt,
    output logic [LVL_W-1:0] fifo_level
);
    localparam int N  = IN_W / OUT_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST_IDX = CW'(N - 1);
    localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state;
    logic [IN_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [IN_W-1:0] head;
    logic [IN_W-1:0] hold;
    logic [CW-1:0]   idx;
    logic            push;
    logic            pop;

    function automatic logic [OUT_W-1:0] window_slice(input logic [IN_W-1:0] word,
                                                      input logic [SH_W-1:0] amt);
        logic [IN_W-1:0] shifted;
        // Shifting by IN_W or more yields zero, which covers out-of-range offsets.
        shifted = word >> (STEP * int'(amt));
        return shifted[OUT_W-1:0];
    endfunction

    assign bus.in_ready = (fifo_level != FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign head         = mem[rd_ptr];
    // Load when idle, or when the last slice leaves so the next word follows with no bubble.
    assign pop = (fifo_level != '0) &&
                 ((state == IDLE) || (bus.out_ready && bus.out_last));

    // NOTE: the storage array has no reset; pointers and level alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            idx           <= '0;
            hold          <= '0;
        end else if (pop) begin
            state         <= EMIT;
            bus.out_valid <= 1'b1;
            hold          <= head;
            idx           <= '0;
            bus.out_data  <= mode ? head[OUT_W-1:0] : window_slice(head, sh_amt);
            bus.out_last  <= !mode || (N == 1);
        end else if (state == EMIT && bus.out_ready) begin
            if (bus.out_last) begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
            end else begin
                idx          <= idx + CW'(1);
                bus.out_data <= hold[(int'(idx) + 1) * OUT_W +: OUT_W];
                bus.out_last <= (idx + CW'(1) == LAST_IDX);
            end
        end
    end
endmodule

// File: tb/tb_word_slicer.sv
// Directed bench for word_slicer: a 32->8 and a 64->16 instance driven in turn
// through shared stimulus, each checked against hand-computed slices.
module tb_word_slicer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] din = '0;
    logic        din_valid = 1'b0;
    logic        dout_ready = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  sh_amt = '0;
    int          u = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    word_slicer_if #(.IN_W(32), .OUT_W(8))  b32 ();
    word_slicer_if #(.IN_W(64), .OUT_W(16)) b64 ();
    logic [2:0] lvl32;
    logic [3:0] lvl64;

    assign b32.in_data   = din[31:0];
    assign b32.in_valid  = din_valid && (u == 0);
    assign b32.out_ready = dout_ready && (u == 0);
    assign b64.in_data   = din;
    assign b64.in_valid  = din_valid && (u == 1);
    assign b64.out_ready = dout_ready && (u == 1);

    word_slicer #(.IN_W(32), .OUT_W(8), .STEP(2), .DEPTH(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(b32), .mode(mode), .sh_amt(sh_amt), .fifo_level(lvl32)
    );
    word_slicer #(.IN_W(64), .OUT_W(16), .STEP(4), .DEPTH(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(b64), .mode(mode), .sh_amt(sh_amt), .fifo_level(lvl64)
    );

    logic        obs_valid;
    logic        obs_last;
    logic        obs_ready;
    logic [15:0] obs_data;
    logic [3:0]  obs_level;

    always_comb begin
        obs_valid = b32.out_valid;
        obs_last  = b32.out_last;
        obs_ready = b32.in_ready;
        obs_data  = 16'(b32.out_data);
        obs_level = 4'(lvl32);
        if (u == 1) begin
            obs_valid = b64.out_valid;
            obs_last  = b64.out_last;
            obs_ready = b64.in_ready;
            obs_data  = b64.out_data;
            obs_level = lvl64;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL u%0d %s: got %0h expected %0h", u, tag, got, exp);
        end
    endtask

    // Reference slice i of a word for the unit under test.
    function automatic logic [15:0] sl(input logic [63:0] w, input int i);
        logic [63:0] s;
        s = w >> (i * ((u == 0) ? 8 : 16));
        return (u == 0) ? {8'h00, s[7:0]} : s[15:0];
    endfunction

    task automatic push(input logic [63:0] w);
        din       = w;
        din_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (obs_ready) begin
                step();
                din_valid = 1'b0;
                return;
            end
            step();
        end
        din_valid = 1'b0;
        check("push timeout", 32'd0, 32'd1);
    endtask

    task automatic run_unit(input int sel,
                            input logic [63:0] win_word, input logic [3:0][15:0] win_exp,
                            input logic [63:0] str_word, input logic [3:0][15:0] str_exp);
        int          sh_tab[4] = '{0, 4, 13, 15};
        int          depth;
        int          nw;
        logic        pushed;
        logic [63:0] bw[10];

        u          = sel;
        depth      = (sel == 0) ? 4 : 8;
        nw         = depth + 2;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        mode       = 1'b0;
        sh_amt     = '0;
        for (int j = 0; j < 10; j++) begin
            bw[j] = 64'h0F1E2D3C4B5A6978 + 64'(j) * 64'h1111111111111111;
            if (sel == 0) bw[j][63:32] = '0;
        end

        rst_n = 1'b0;
        step();
        step();
        check("rst valid", 32'(obs_valid), 32'd0);
        check("rst data",  32'(obs_data),  32'd0);
        check("rst last",  32'(obs_last),  32'd0);
        check("rst level", 32'(obs_level), 32'd0);
        check("rst ready", 32'(obs_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Window mode, one slice per word.
        dout_ready = 1'b1;
        mode       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sh_amt = 4'(sh_tab[i]);
            push(win_word);
            if (i == 0) check("win latency", 32'(obs_valid), 32'd0);
            step();
            check("win slice", {obs_valid, obs_last, obs_data}, {1'b1, 1'b1, win_exp[i]});
            step();
            check("win idle", 32'(obs_valid), 32'd0);
        end

        // Stream mode, all slices LSB first.
        mode = 1'b1;
        push(str_word);
        check("str latency", 32'(obs_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("str slice", {obs_valid, obs_last, obs_data}, {1'b1, i == 3, str_exp[i]});
        end
        step();
        check("str idle", 32'(obs_valid), 32'd0);

        // Back-pressure: fill the FIFO, hold, then drain without loss or bubble.
        dout_ready = 1'b0;
        for (int j = 0; j < nw - 1; j++) push(bw[j]);
        din       = bw[nw-1];
        din_valid = 1'b1;
        for (int c = 0; c < 8; c++) step();
        check("bp level", 32'(obs_level), 32'(depth));
        check("bp ready", 32'(obs_ready), 32'd0);
        check("bp hold",  {obs_valid, obs_last, obs_data}, {1'b1, 1'b0, sl(bw[0], 0)});
        pushed = 1'b0;
        fork
            begin
                for (int c = 0; c < 20 && !pushed; c++) begin
                    if (obs_ready) pushed = 1'b1;
                    step();
                end
                din_valid = 1'b0;
            end
            begin
                dout_ready = 1'b1;
                for (int s = 0; s < nw * 4; s++) begin
                    check("bp slice", {obs_valid, obs_last, obs_data},
                          {1'b1, (s % 4) == 3, sl(bw[s / 4], s % 4)});
                    step();
                end
            end
        join
        check("bp late push", 32'(pushed), 32'd1);
        check("bp drained", {obs_valid, obs_level}, 32'd0);

        // Mode/offset changes mid-word apply only to the next word.
        mode   = 1'b1;
        sh_amt = '0;
        push(str_word);
        step();
        check("latch s0", {obs_valid, obs_last, obs_data}, {1'b1, 1'b0, str_exp[0]});
        mode      = 1'b0;
        sh_amt    = 4'd4;
        din       = win_word;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("latch stream", {obs_valid, obs_last, obs_data}, {1'b1, i == 3, str_exp[i]});
            step();
        end
        check("latch window", {obs_valid, obs_last, obs_data}, {1'b1, 1'b1, win_exp[1]});
        step();
        check("latch idle", 32'(obs_valid), 32'd0);

        // Reset mid-stream with three words queued.
        dout_ready = 1'b0;
        mode       = 1'b1;
        for (int j = 0; j < 4; j++) push(bw[j]);
        check("mid level", 32'(obs_level), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid rst out",   {obs_valid, obs_last, obs_data}, 32'd0);
        check("mid rst level", 32'(obs_level), 32'd0);
        check("mid rst ready", 32'(obs_ready), 32'd1);
        step();
        step();
        rst_n      = 1'b1;
        dout_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("post rst idle", {obs_valid, obs_level}, 32'd0);
        end
    endtask

    initial begin
        run_unit(0, 64'hA5C31E7F,
                 {16'h0002, 16'h0029, 16'h001E, 16'h007F},
                 64'h12345678,
                 {16'h0012, 16'h0034, 16'h0056, 16'h0078});
        run_unit(1, 64'hA5C31E7F01234567,
                 {16'h000A, 16'h0A5C, 16'h0123, 16'h4567},
                 64'h1122334455667788,
                 {16'h1122, 16'h3344, 16'h5566, 16'h7788});
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end
endmodule
